// File: rtl/mips_pkg.sv
// Shared pipeline constants: control bundle widths, bit positions and NOP encodings.
package mips_pkg;

  localparam int unsigned CTRL_EX_W = 4;  // {RegDst, ALUOp[1:0], ALUSrc}
  localparam int unsigned CTRL_M_W  = 3;  // {Branch, MemRead, MemWrite}
  localparam int unsigned CTRL_WB_W = 2;  // {RegWrite, MemtoReg}

  localparam int unsigned M_MEMREAD   = 1;
  localparam int unsigned WB_REGWRITE = 1;

  localparam logic [CTRL_EX_W-1:0] NOP_EX = '0;
  localparam logic [CTRL_M_W-1:0]  NOP_M  = '0;
  localparam logic [CTRL_WB_W-1:0] NOP_WB = '0;

  typedef struct packed {
    logic [CTRL_EX_W-1:0] ex;
    logic [CTRL_M_W-1:0]  m;
    logic [CTRL_WB_W-1:0] wb;
  } ctrl_t;

  localparam ctrl_t NOP_CTRL = '{ex: NOP_EX, m: NOP_M, wb: NOP_WB};

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-side inputs, EX-side registered outputs, stall feedback.
interface id_ex_pipe_reg_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);

  // ID side
  logic [CTRL_EX_W-1:0] id_ex;
  logic [CTRL_M_W-1:0]  id_m;
  logic [CTRL_WB_W-1:0] id_wb;
  logic [DATA_W-1:0]    id_npc;
  logic [DATA_W-1:0]    id_rd1;
  logic [DATA_W-1:0]    id_rd2;
  logic [DATA_W-1:0]    id_imm;
  logic [REG_AW-1:0]    id_rs;
  logic [REG_AW-1:0]    id_rt;
  logic [REG_AW-1:0]    id_rd;
  logic                 id_valid;
  logic                 flush_i;

  // EX side
  logic [CTRL_EX_W-1:0] ex_ex;
  logic [CTRL_M_W-1:0]  ex_m;
  logic [CTRL_WB_W-1:0] ex_wb;
  logic [DATA_W-1:0]    ex_npc;
  logic [DATA_W-1:0]    ex_rd1;
  logic [DATA_W-1:0]    ex_rd2;
  logic [DATA_W-1:0]    ex_imm;
  logic [REG_AW-1:0]    ex_rs;
  logic [REG_AW-1:0]    ex_rt;
  logic [REG_AW-1:0]    ex_rd;
  logic                 ex_valid;
  logic                 stall_o;
  logic [CNT_W-1:0]     stall_cnt;

  // Upstream decode logic / testbench side
  modport master (
    output id_ex, id_m, id_wb, id_npc, id_rd1, id_rd2, id_imm,
    output id_rs, id_rt, id_rd, id_valid, flush_i,
    input  ex_ex, ex_m, ex_wb, ex_npc, ex_rd1, ex_rd2, ex_imm,
    input  ex_rs, ex_rt, ex_rd, ex_valid, stall_o, stall_cnt
  );

  // Pipeline register side
  modport slave (
    input  id_ex, id_m, id_wb, id_npc, id_rd1, id_rd2, id_imm,
    input  id_rs, id_rt, id_rd, id_valid, flush_i,
    output ex_ex, ex_m, ex_wb, ex_npc, ex_rd1, ex_rd2, ex_imm,
    output ex_rs, ex_rt, ex_rd, ex_valid, stall_o, stall_cnt
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              hz
);

  // $0 is hardwired, so a load targeting it never creates a dependency
  always_comb begin
    hz = ex_valid & ex_memread & (ex_rt != '0) & id_valid &
         ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, branch flush and saturating stall counter.
module id_ex_pipe_reg
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_pipe_reg_if.slave  bus
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] npc_q, npc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;
  logic              stall;
  logic              bubble;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_valid   (valid_q),
    .ex_memread (ctrl_q.m[M_MEMREAD]),
    .ex_rt      (rt_q),
    .id_valid   (bus.id_valid),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .hz         (hz)
  );

  // Flush overrides the stall: the dependent instruction is being killed anyway
  always_comb begin
    stall  = hz & ~bus.flush_i;
    bubble = bus.flush_i | stall;
  end

  // Next-state: capture ID, or insert a bubble; data fields are captured regardless
  always_comb begin
    ctrl_d  = '{ex: bus.id_ex, m: bus.id_m, wb: bus.id_wb};
    npc_d   = bus.id_npc;
    rd1_d   = bus.id_rd1;
    rd2_d   = bus.id_rd2;
    imm_d   = bus.id_imm;
    rs_d    = bus.id_rs;
    rt_d    = bus.id_rt;
    rd_d    = bus.id_rd;
    valid_d = bus.id_valid & ~bubble;
    if (bubble || !bus.id_valid) begin
      ctrl_d = NOP_CTRL;
    end
  end

  // Pipeline register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= NOP_CTRL;
      npc_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      npc_q   <= npc_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  // Saturating stall-cycle count
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Output drive
  always_comb begin
    bus.ex_ex     = ctrl_q.ex;
    bus.ex_m      = ctrl_q.m;
    bus.ex_wb     = ctrl_q.wb;
    bus.ex_npc    = npc_q;
    bus.ex_rd1    = rd1_q;
    bus.ex_rd2    = rd2_q;
    bus.ex_imm    = imm_q;
    bus.ex_rs     = rs_q;
    bus.ex_rt     = rt_q;
    bus.ex_rd     = rd_q;
    bus.ex_valid  = valid_q;
    bus.stall_o   = stall;
    bus.stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected EX contents are queued when an
// instruction is presented and compared after the capturing edge.
module tb_id_ex_pipe_reg;
  import mips_pkg::*;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SAT_W  = 2;

  typedef struct packed {
    logic [3:0]  ex;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic [31:0] npc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checks = 0;
  int errors = 0;

  obs_t sb_q[$];
  obs_t mdl;       // expected EX contents (data masked when invalid)
  obs_t pend;      // what the coming edge should load
  obs_t exp_o;
  logic exp_stall;
  int   mdl_cnt;
  int   sat_cnt;

  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();
  id_ex_pipe_reg_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(SAT_W)) sat_bus ();

  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Narrow-counter copy sees identical stimulus, so its count saturates quickly
  id_ex_pipe_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(SAT_W)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  assign sat_bus.id_ex    = bus.id_ex;
  assign sat_bus.id_m     = bus.id_m;
  assign sat_bus.id_wb    = bus.id_wb;
  assign sat_bus.id_npc   = bus.id_npc;
  assign sat_bus.id_rd1   = bus.id_rd1;
  assign sat_bus.id_rd2   = bus.id_rd2;
  assign sat_bus.id_imm   = bus.id_imm;
  assign sat_bus.id_rs    = bus.id_rs;
  assign sat_bus.id_rt    = bus.id_rt;
  assign sat_bus.id_rd    = bus.id_rd;
  assign sat_bus.id_valid = bus.id_valid;
  assign sat_bus.flush_i  = bus.flush_i;

  always #5 clk = ~clk;

  function automatic obs_t raw();
    return {bus.ex_ex, bus.ex_m, bus.ex_wb, bus.ex_npc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
            bus.ex_rs, bus.ex_rt, bus.ex_rd, bus.ex_valid};
  endfunction

  // Data and specifiers are don't-care while EX holds a bubble
  function automatic obs_t observe();
    obs_t o;
    o = raw();
    if (!o.valid) begin
      o.npc = '0; o.rd1 = '0; o.rd2 = '0; o.imm = '0;
      o.rs = '0; o.rt = '0; o.rd = '0;
    end
    return o;
  endfunction

  task automatic idle_inputs();
    bus.id_ex = '0; bus.id_m = '0; bus.id_wb = '0;
    bus.id_npc = '0; bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_valid = 1'b0; bus.flush_i = 1'b0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    mdl = '0; pend = '0; exp_stall = 1'b0;
    mdl_cnt = 0; sat_cnt = 0;
    idle_inputs();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one ID instruction at the negedge and queue what EX should hold next
  task automatic present(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic vld, input logic fl);
    obs_t nxt;
    logic hz;
    @(negedge clk);
    bus.id_ex = ex; bus.id_m = m; bus.id_wb = wb;
    bus.id_npc = $urandom(); bus.id_rd1 = $urandom();
    bus.id_rd2 = $urandom(); bus.id_imm = $urandom();
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_valid = vld; bus.flush_i = fl;
    hz = mdl.valid && mdl.m[M_MEMREAD] && (mdl.rt != 5'd0) && vld &&
         ((mdl.rt == rs) || (mdl.rt == rt));
    exp_stall = hz && !fl;
    if (fl || exp_stall || !vld) nxt = '0;
    else nxt = {ex, m, wb, bus.id_npc, bus.id_rd1, bus.id_rd2, bus.id_imm, rs, rt, rd, 1'b1};
    sb_q.push_back(nxt);
    pend = nxt;
    #1;
  endtask

  task automatic clock_edge();
    @(posedge clk);
    #1;
    mdl = pend;
    if (exp_stall && mdl_cnt < 65535) mdl_cnt++;
    if (exp_stall && sat_cnt < 3) sat_cnt++;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (raw() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", raw());
    end
    checks++;
    if (bus.stall_o !== 1'b0 || bus.stall_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_stall: got stall %b cnt %h want 0 0", bus.stall_o, bus.stall_cnt);
    end
    model_reset();
    release_reset();
    present(4'b0011, 3'b000, 2'b10, 5'd4, 5'd6, 5'd9, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL reset_preload: got %h want %h", observe(), exp_o);
    end
    // Assert reset between edges while EX holds a valid instruction
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (raw() !== '0) begin
      errors++; $display("FAIL reset_async: got %h want 0", raw());
    end
    model_reset();
    release_reset();
  endtask

  task automatic test_rtype();
    present(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL rtype_stall: got %b want 0", bus.stall_o);
    end
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL rtype_capture: got %h want %h", observe(), exp_o);
    end
    checks++;
    if (bus.ex_ex !== 4'b1100 || bus.ex_wb !== 2'b10 || bus.ex_rd !== 5'd3 || bus.ex_valid !== 1'b1)
    begin
      errors++;
      $display("FAIL rtype_fields: got ex %b wb %b rd %0d v %b want 1100 10 3 1",
               bus.ex_ex, bus.ex_wb, bus.ex_rd, bus.ex_valid);
    end
  endtask

  task automatic test_load_use();
    present(4'b0001, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL lw_capture: got %h want %h", observe(), exp_o);
    end
    present(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL lu_stall: got %b want 1", bus.stall_o);
    end
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o || bus.ex_m !== 3'b000 || bus.ex_valid !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got %h want %h", observe(), exp_o);
    end
    checks++;
    if (bus.stall_cnt !== 16'd1) begin
      errors++; $display("FAIL lu_count: got %0d want 1", bus.stall_cnt);
    end
    present(4'b1100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL lu_release: got %b want 0", bus.stall_o);
    end
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL lu_add_capture: got %h want %h", observe(), exp_o);
    end
  endtask

  task automatic test_load_r0();
    present(4'b0001, 3'b010, 2'b11, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    present(4'b1100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL r0_stall: got %b want 0", bus.stall_o);
    end
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL r0_capture: got %h want %h", observe(), exp_o);
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    present(4'b0001, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    cnt_before = mdl_cnt;
    present(4'b1100, 3'b000, 2'b10, 5'd5, 5'd5, 5'd7, 1'b1, 1'b1);
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL flush_stall: got %b want 0", bus.stall_o);
    end
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL flush_bubble: got %h want %h", observe(), exp_o);
    end
    checks++;
    if (bus.stall_cnt !== 16'(cnt_before)) begin
      errors++; $display("FAIL flush_count: got %0d want %0d", bus.stall_cnt, cnt_before);
    end
    // Invalid ID slot with live control bits must still load a NOP
    present(4'b1111, 3'b111, 2'b11, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL invalid_nop: got %h want %h", observe(), exp_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      present(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 10));
      checks++;
      if (bus.stall_o !== exp_stall) begin
        errors++; $display("FAIL b2b_stall[%0d]: got %b want %b", i, bus.stall_o, exp_stall);
      end
      clock_edge();
      exp_o = sb_q.pop_front();
      checks++;
      if (observe() !== exp_o) begin
        errors++; $display("FAIL b2b_ex[%0d]: got %h want %h", i, observe(), exp_o);
      end
      checks++;
      if (bus.stall_cnt !== 16'(mdl_cnt)) begin
        errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, bus.stall_cnt, mdl_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    // Chained dependent loads: every other cycle stalls
    for (int i = 0; i < 10; i++) begin
      present(4'b0001, 3'b010, 2'b11, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      clock_edge();
      exp_o = sb_q.pop_front();
      checks++;
      if (sat_bus.stall_cnt !== 2'(sat_cnt)) begin
        errors++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, sat_bus.stall_cnt, sat_cnt);
      end
    end
    checks++;
    if (sat_bus.stall_cnt !== 2'b11 || bus.stall_cnt !== 16'(mdl_cnt)) begin
      errors++;
      $display("FAIL sat_hold: got %0d/%0d want 3/%0d", sat_bus.stall_cnt, bus.stall_cnt, mdl_cnt);
    end
  endtask

  task automatic test_reset_mid_stall();
    present(4'b0001, 3'b010, 2'b11, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    present(4'b1100, 3'b000, 2'b10, 5'd2, 5'd9, 5'd7, 1'b1, 1'b0);
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL mid_stall_pre: got %b want 1", bus.stall_o);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0 || bus.ex_valid !== 1'b0 || bus.stall_cnt !== 16'h0) begin
      errors++;
      $display("FAIL mid_stall_reset: got stall %b valid %b cnt %0d want 0 0 0",
               bus.stall_o, bus.ex_valid, bus.stall_cnt);
    end
    model_reset();
    release_reset();
    present(4'b1100, 3'b000, 2'b10, 5'd2, 5'd9, 5'd7, 1'b1, 1'b0);
    clock_edge();
    exp_o = sb_q.pop_front();
    checks++;
    if (observe() !== exp_o) begin
      errors++; $display("FAIL post_reset_capture: got %h want %h", observe(), exp_o);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_load_r0();
    test_flush();
    test_back_to_back();
    test_saturate();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
